// File: rtl/demux_12.sv
// Splits an interleaved word stream into two lanes, alternating per accepted word.
// Each lane is a FIFO with a valid/ready pop side; a full selected lane stalls the input.
module demux_12 #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic                    resync,
    output logic [WIDTH-1:0]        data_out_0,
    output logic [WIDTH-1:0]        data_out_1,
    output logic                    valid_0,
    output logic                    valid_1,
    input  logic                    ready_0,
    input  logic                    ready_1,
    output logic [$clog2(DEPTH):0]  fill_0,
    output logic [$clog2(DEPTH):0]  fill_1
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic                   sel_q, sel_d;
    logic [WIDTH-1:0]       mem_q  [2][DEPTH];
    logic [PTR_W-1:0]       wptr_q [2];
    logic [PTR_W-1:0]       wptr_d [2];
    logic [PTR_W-1:0]       rptr_q [2];
    logic [PTR_W-1:0]       rptr_d [2];
    logic [CNT_W-1:0]       fill_q [2];
    logic [CNT_W-1:0]       fill_d [2];
    logic [1:0]             full_c;
    logic [1:0]             push_c;
    logic [1:0]             pop_c;
    logic [1:0]             lane_rdy_c;
    logic                   accept_c;

    // Handshake decode and next-state for selector, pointers and occupancy
    always_comb begin
        lane_rdy_c = {ready_1, ready_0};
        for (int n = 0; n < 2; n++) begin
            full_c[n] = (fill_q[n] == CNT_W'(DEPTH));
            pop_c[n]  = (fill_q[n] != '0) & lane_rdy_c[n];
        end
        ready_in  = ~full_c[sel_q];
        accept_c  = valid_in & ready_in;
        push_c[0] = accept_c & ~sel_q;
        push_c[1] = accept_c &  sel_q;

        // resync overrides the toggle; an accepted word still uses the old lane
        sel_d = sel_q;
        if (resync) begin
            sel_d = 1'b0;
        end else if (accept_c) begin
            sel_d = ~sel_q;
        end

        for (int n = 0; n < 2; n++) begin
            wptr_d[n] = wptr_q[n] + PTR_W'(push_c[n]);
            rptr_d[n] = rptr_q[n] + PTR_W'(pop_c[n]);
            fill_d[n] = fill_q[n];
            if (push_c[n] && !pop_c[n]) begin
                fill_d[n] = fill_q[n] + CNT_W'(1);
            end else if (pop_c[n] && !push_c[n]) begin
                fill_d[n] = fill_q[n] - CNT_W'(1);
            end
        end
    end

    // State registers, including lane memories, cleared asynchronously
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            sel_q <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
                fill_q[n] <= '0;
                for (int e = 0; e < int'(DEPTH); e++) begin
                    mem_q[n][e] <= '0;
                end
            end
        end else begin
            sel_q <= sel_d;
            for (int n = 0; n < 2; n++) begin
                wptr_q[n] <= wptr_d[n];
                rptr_q[n] <= rptr_d[n];
                fill_q[n] <= fill_d[n];
                if (push_c[n]) begin
                    mem_q[n][wptr_q[n]] <= data_in;
                end
            end
        end
    end

    assign data_out_0 = mem_q[0][rptr_q[0]];
    assign data_out_1 = mem_q[1][rptr_q[1]];
    assign valid_0    = (fill_q[0] != '0);
    assign valid_1    = (fill_q[1] != '0);
    assign fill_0     = fill_q[0];
    assign fill_1     = fill_q[1];

endmodule

// File: tb/tb_demux_12.sv
// Directed vector bench for demux_12: table of per-cycle inputs and expected lane state.
module tb_demux_12;

    logic       clk;
    logic       reset_L;
    logic [3:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic       resync;
    logic [3:0] data_out_0;
    logic [3:0] data_out_1;
    logic       valid_0;
    logic       valid_1;
    logic       ready_0;
    logic       ready_1;
    logic [2:0] fill_0;
    logic [2:0] fill_1;

    int total;
    int bad;

    typedef struct {
        logic       vin;
        logic [3:0] din;
        logic       rs;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic [2:0] e_f0;
        logic [3:0] e_d0;
        logic [2:0] e_f1;
        logic [3:0] e_d1;
    } vec_t;

    vec_t vecs[$];

    demux_12 #(.WIDTH(4), .DEPTH(4)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .resync     (resync),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .valid_0    (valid_0),
        .valid_1    (valid_1),
        .ready_0    (ready_0),
        .ready_1    (ready_1),
        .fill_0     (fill_0),
        .fill_1     (fill_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int vin, input int din, input int rs, input int r0,
                                input int r1, input int rdy, input int f0, input int d0,
                                input int f1, input int d1);
        vec_t v;
        v.vin   = 1'(vin);
        v.din   = 4'(din);
        v.rs    = 1'(rs);
        v.r0    = 1'(r0);
        v.r1    = 1'(r1);
        v.e_rdy = 1'(rdy);
        v.e_f0  = 3'(f0);
        v.e_d0  = 4'(d0);
        v.e_f1  = 3'(f1);
        v.e_d1  = 4'(d1);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Compare lane outputs against a record; head data only matters while valid
    task automatic check_state(input string tag, input vec_t v);
        chk({tag, ".ready_in"}, int'(ready_in), int'(v.e_rdy));
        chk({tag, ".fill_0"},   int'(fill_0),   int'(v.e_f0));
        chk({tag, ".fill_1"},   int'(fill_1),   int'(v.e_f1));
        chk({tag, ".valid_0"},  int'(valid_0),  int'(v.e_f0 != 3'd0));
        chk({tag, ".valid_1"},  int'(valid_1),  int'(v.e_f1 != 3'd0));
        if (v.e_f0 != 3'd0) chk({tag, ".data_out_0"}, int'(data_out_0), int'(v.e_d0));
        if (v.e_f1 != 3'd0) chk({tag, ".data_out_1"}, int'(data_out_1), int'(v.e_d1));
    endtask

    task automatic apply(input string tag, input vec_t v);
        valid_in = v.vin;
        data_in  = v.din;
        resync   = v.rs;
        ready_0  = v.r0;
        ready_1  = v.r1;
        @(posedge clk);
        #1;
        check_state(tag, v);
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 4'h0;
        resync   = 1'b0;
        ready_0  = 1'b0;
        ready_1  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid_0"},    int'(valid_0),    0);
        chk({tag, ".valid_1"},    int'(valid_1),    0);
        chk({tag, ".fill_0"},     int'(fill_0),     0);
        chk({tag, ".fill_1"},     int'(fill_1),     0);
        chk({tag, ".data_out_0"}, int'(data_out_0), 0);
        chk({tag, ".data_out_1"}, int'(data_out_1), 0);
        chk({tag, ".ready_in"},   int'(ready_in),   1);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // mk(valid_in, data_in, resync, ready_0, ready_1 | ready_in, fill_0, head0, fill_1, head1)
        // Basic stream, both lanes draining
        vecs.push_back(mk(1, 4'h1, 0, 1, 1,  1, 1, 4'h1, 0, 0));
        vecs.push_back(mk(1, 4'h2, 0, 1, 1,  1, 0, 0,    1, 4'h2));
        vecs.push_back(mk(1, 4'h3, 0, 1, 1,  1, 1, 4'h3, 0, 0));
        vecs.push_back(mk(1, 4'h4, 0, 1, 1,  1, 0, 0,    1, 4'h4));
        vecs.push_back(mk(0, 0,    0, 1, 1,  1, 0, 0,    0, 0));
        // Both lanes stalled until full
        vecs.push_back(mk(1, 4'hA, 0, 0, 0,  1, 1, 4'hA, 0, 0));
        vecs.push_back(mk(1, 4'hB, 0, 0, 0,  1, 1, 4'hA, 1, 4'hB));
        vecs.push_back(mk(1, 4'hC, 0, 0, 0,  1, 2, 4'hA, 1, 4'hB));
        vecs.push_back(mk(1, 4'hD, 0, 0, 0,  1, 2, 4'hA, 2, 4'hB));
        vecs.push_back(mk(1, 4'hE, 0, 0, 0,  1, 3, 4'hA, 2, 4'hB));
        vecs.push_back(mk(1, 4'hF, 0, 0, 0,  1, 3, 4'hA, 3, 4'hB));
        vecs.push_back(mk(1, 4'h0, 0, 0, 0,  1, 4, 4'hA, 3, 4'hB));
        vecs.push_back(mk(1, 4'h1, 0, 0, 0,  0, 4, 4'hA, 4, 4'hB));
        vecs.push_back(mk(1, 4'h2, 0, 0, 0,  0, 4, 4'hA, 4, 4'hB));
        vecs.push_back(mk(1, 4'h2, 0, 0, 0,  0, 4, 4'hA, 4, 4'hB));
        // Full lane pops while input is blocked; accept only on the following cycle
        vecs.push_back(mk(1, 4'h2, 0, 1, 0,  1, 3, 4'hC, 4, 4'hB));
        vecs.push_back(mk(1, 4'h2, 0, 1, 0,  0, 3, 4'hE, 4, 4'hB));
        vecs.push_back(mk(1, 4'h3, 0, 1, 1,  1, 2, 4'h0, 3, 4'hD));
        vecs.push_back(mk(1, 4'h3, 0, 1, 1,  1, 1, 4'h2, 3, 4'hF));
        vecs.push_back(mk(0, 0,    0, 1, 1,  1, 0, 0,    2, 4'h1));
        vecs.push_back(mk(0, 0,    0, 1, 1,  1, 0, 0,    1, 4'h3));
        vecs.push_back(mk(0, 0,    0, 1, 1,  1, 0, 0,    0, 0));
        // resync with and without an accept
        vecs.push_back(mk(1, 4'h6, 0, 0, 0,  1, 1, 4'h6, 0, 0));
        vecs.push_back(mk(1, 4'h7, 1, 0, 0,  1, 1, 4'h6, 1, 4'h7));
        vecs.push_back(mk(1, 4'h8, 0, 0, 0,  1, 2, 4'h6, 1, 4'h7));
        vecs.push_back(mk(1, 4'h9, 1, 0, 0,  1, 2, 4'h6, 2, 4'h7));
        vecs.push_back(mk(1, 4'hA, 0, 0, 0,  1, 3, 4'h6, 2, 4'h7));
        vecs.push_back(mk(0, 0,    1, 0, 0,  1, 3, 4'h6, 2, 4'h7));
        vecs.push_back(mk(1, 4'hB, 0, 0, 0,  1, 4, 4'h6, 2, 4'h7));
        vecs.push_back(mk(0, 0,    0, 1, 0,  1, 3, 4'h8, 2, 4'h7));

        do_reset();
        check_zero("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges with fill_0=3, fill_1=2
        #2;
        reset_L = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        reset_L = 1'b1;
        apply("post_rst0", mk(1, 4'h5, 0, 0, 0,  1, 1, 4'h5, 0, 0));
        apply("post_rst1", mk(1, 4'h6, 0, 0, 0,  1, 1, 4'h5, 1, 4'h6));

        // Full-rate stream across several pointer wraps
        do_reset();
        check_zero("reset2");
        for (int i = 0; i < 20; i++) begin
            int w;
            w = (i * 3 + 1) % 16;
            if (i % 2 == 0)
                apply($sformatf("wrap%0d", i), mk(1, w, 0, 1, 1,  1, 1, w, 0, 0));
            else
                apply($sformatf("wrap%0d", i), mk(1, w, 0, 1, 1,  1, 0, 0, 1, w));
        end
        apply("wrap_end", mk(0, 0, 0, 1, 1,  1, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
